// File: rtl/spi_sram_master.sv
// spi_sram_master: SPI mode-0 initiator for the SPI SRAM slave.
// Frame is a command bit (1=write), then address, then data, all MSB first.
module spi_sram_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdoM,
    input  logic              sdiM,
    output logic              comload,
    output logic              addrload,
    output logic              dataload
);
    // state | meaning
    // IDLE  | cs_n high, ready for a request
    // CMD   | command bit on sdoM
    // ADDR  | address bits, MSB first
    // DATA  | write data out, or read data sampled in
    // DONE  | one-cycle response strobe, cs_n high

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BIT_W = $clog2(MAX_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_cnt, div_nx;
    logic [BIT_W-1:0]  bit_cnt, bit_nx;
    logic              hi, hi_nx;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_sr, addr_sr_nx;
    logic [DATA_W-1:0] tx_sr, tx_sr_nx;
    logic [DATA_W-1:0] rx_sr, rx_sr_nx;
    logic              accept;
    logic              busy;
    logic              busy_nx;
    logic              rise_edge;
    logic              bit_end;
    logic              sdo_nx;

    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign busy      = (state == CMD) || (state == ADDR) || (state == DATA);
    assign rise_edge = busy && !hi && (div_cnt == DIV_LAST);
    assign bit_end   = busy && hi && (div_cnt == DIV_LAST);

    always_comb begin
        state_nx   = state;
        div_nx     = div_cnt;
        bit_nx     = bit_cnt;
        hi_nx      = hi;
        addr_sr_nx = addr_sr;
        tx_sr_nx   = tx_sr;
        rx_sr_nx   = rx_sr;

        if (busy) begin
            if (div_cnt == DIV_LAST) begin
                div_nx = '0;
                hi_nx  = !hi;
            end else begin
                div_nx = div_cnt + 1'b1;
            end
        end

        // read data is captured on the edge that raises sclk
        if (rise_edge && (state == DATA) && !wr_q)
            rx_sr_nx = (rx_sr << 1) | DATA_W'(sdiM);

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx   = CMD;
                    div_nx     = '0;
                    bit_nx     = '0;
                    hi_nx      = 1'b0;
                    addr_sr_nx = req_addr;
                    tx_sr_nx   = req_wdata;
                end
            end
            CMD: begin
                if (bit_end) begin
                    state_nx = ADDR;
                    bit_nx   = '0;
                end
            end
            ADDR: begin
                if (bit_end) begin
                    addr_sr_nx = addr_sr << 1;
                    if (bit_cnt == ADDR_LAST) begin
                        state_nx = DATA;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    tx_sr_nx = tx_sr << 1;
                    if (bit_cnt == DATA_LAST) begin
                        state_nx = DONE;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Serial output follows the bit position, so it only moves at bit boundaries.
    always_comb begin
        busy_nx = (state_nx == CMD) || (state_nx == ADDR) || (state_nx == DATA);
        case (state_nx)
            CMD:     sdo_nx = accept ? req_write : wr_q;
            ADDR:    sdo_nx = addr_sr_nx[ADDR_W-1];
            DATA:    sdo_nx = wr_q & tx_sr_nx[DATA_W-1];
            default: sdo_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            hi        <= 1'b0;
            wr_q      <= 1'b0;
            addr_sr   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            sdoM      <= 1'b0;
            comload   <= 1'b0;
            addrload  <= 1'b0;
            dataload  <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            bit_cnt <= bit_nx;
            hi      <= hi_nx;
            addr_sr <= addr_sr_nx;
            tx_sr   <= tx_sr_nx;
            rx_sr   <= rx_sr_nx;
            if (accept)
                wr_q <= req_write;
            req_ready <= (state_nx == IDLE);
            rsp_valid <= (state_nx == DONE);
            if ((state_nx == DONE) && !wr_q)
                rsp_rdata <= rx_sr;
            cs_n     <= !busy_nx;
            sclk     <= busy_nx && hi_nx;
            sdoM     <= sdo_nx;
            comload  <= (state_nx == CMD);
            addrload <= (state_nx == ADDR);
            dataload <= (state_nx == DATA);
        end
    end

endmodule

// File: tb/tb_spi_sram_master.sv
// tb_spi_sram_master: checks frames of a CLK_DIV=2 and a CLK_DIV=1 instance
// against a frame-level model (bit sequence, cs_n low time, response latency).
module tb_spi_sram_master;
    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       sdiM;
    logic       sel;
    logic [7:0] slave_byte;

    logic       r0, rv0, cs0, sc0, so0, cl0, al0, dl0;
    logic       r1, rv1, cs1, sc1, so1, cl1, al1, dl1;
    logic [7:0] rd0, rd1;

    spi_sram_master #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(2)) dut0 (
        .clock(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(r0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .cs_n(cs0), .sclk(sc0), .sdoM(so0),
        .sdiM(sdiM), .comload(cl0), .addrload(al0), .dataload(dl0)
    );

    spi_sram_master #(.ADDR_W(8), .DATA_W(8), .CLK_DIV(1)) dut1 (
        .clock(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(r1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .cs_n(cs1), .sclk(sc1), .sdoM(so1),
        .sdiM(sdiM), .comload(cl1), .addrload(al1), .dataload(dl1)
    );

    wire       o_ready = sel ? r1 : r0;
    wire       o_rv    = sel ? rv1 : rv0;
    wire [7:0] o_rd    = sel ? rd1 : rd0;
    wire       o_cs    = sel ? cs1 : cs0;
    wire       o_sclk  = sel ? sc1 : sc0;
    wire       o_sdo   = sel ? so1 : so0;
    wire       o_cl    = sel ? cl1 : cl0;
    wire       o_al    = sel ? al1 : al0;
    wire       o_dl    = sel ? dl1 : dl0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests;
    int n_fail;

    // bus monitor and slave model, sampled on the falling clock edge
    int          cyc = 0;
    int          acc_cnt = 0, acc_cyc = 0;
    int          rsp_cnt = 0, rsp_cyc = 0;
    int          low_cnt = 0, rise_cnt = 0;
    int          cs_rise_cyc = 0, cs_fall_cyc = 0;
    int          data_rises = 0, sl_idx = 0;
    int          viol = 0;
    logic [16:0] cap_bits = '0;
    logic [7:0]  rsp_data = '0;
    logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_sdo = 1'b0;
    logic [7:0]  sh;

    always @(negedge clk) begin
        cyc++;
        if (req_valid && o_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (!o_cs) low_cnt++;
        if (o_cs && !prev_cs) cs_rise_cyc = cyc;
        if (!o_cs && prev_cs) cs_fall_cyc = cyc;
        if (o_sclk && !prev_sclk) begin
            cap_bits = {cap_bits[15:0], o_sdo};
            rise_cnt++;
            if (o_dl) data_rises++;
        end
        if (!o_sclk && prev_sclk) sl_idx = data_rises;
        if (o_cs) begin
            data_rises = 0;
            sl_idx     = 0;
        end
        sh   = slave_byte << sl_idx;
        sdiM = o_dl ? sh[7] : 1'b0;
        if (o_rv) begin
            rsp_cnt++;
            rsp_cyc  = cyc;
            rsp_data = o_rd;
        end
        if (o_cs && (o_sclk || o_cl || o_al || o_dl)) viol++;
        if ((int'(o_cl) + int'(o_al) + int'(o_dl)) > 1) viol++;
        if (!o_cs && (o_sdo != prev_sdo) && !(!o_sclk && (prev_sclk || prev_cs))) viol++;
        prev_sclk = o_sclk;
        prev_cs   = o_cs;
        prev_sdo  = o_sdo;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(input string name, input int target);
        int t = 0;
        while (acc_cnt < target && t < 400) begin
            tick();
            t++;
        end
        check({name, "_accept_seen"}, 32'(acc_cnt >= target), 1);
    endtask

    task automatic wait_rsp(input string name, input int target);
        int t = 0;
        while (rsp_cnt < target && t < 400) begin
            tick();
            t++;
        end
        check({name, "_rsp_seen"}, 32'(rsp_cnt >= target), 1);
    endtask

    typedef struct {
        bit          sel;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  sbyte;
        logic [16:0] exp_bits;
        int          exp_low;
        logic [7:0]  exp_rdata;
    } vec_t;

    function automatic vec_t mk(input bit s, input bit w, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] sb, input logic [16:0] eb, input int el,
                                input logic [7:0] er);
        vec_t v;
        v.sel = s; v.wr = w; v.addr = a; v.wdata = d; v.sbyte = sb;
        v.exp_bits = eb; v.exp_low = el; v.exp_rdata = er;
        return v;
    endfunction

    // frame content: command bit, address, then write data or zeros on a read
    function automatic logic [16:0] model_bits(input bit w, input logic [7:0] a, input logic [7:0] d);
        return {w, a, (w ? d : 8'h00)};
    endfunction

    task automatic do_frame(input int idx, input vec_t v);
        int a0, r0c, l0, rc0;
        string nm;
        nm = $sformatf("v%0d", idx);
        sel = v.sel;
        slave_byte = v.sbyte;
        @(posedge clk); #1;
        a0 = acc_cnt; r0c = rsp_cnt; l0 = low_cnt; rc0 = rise_cnt;
        req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        wait_acc(nm, a0 + 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
        wait_rsp(nm, r0c + 1);
        check({nm, "_bits"}, 32'(cap_bits), 32'(v.exp_bits));
        check({nm, "_rises"}, rise_cnt - rc0, 17);
        check({nm, "_cs_low"}, low_cnt - l0, v.exp_low);
        check({nm, "_rsp_latency"}, rsp_cyc - acc_cyc, v.exp_low + 1);
        check({nm, "_rdata"}, 32'(rsp_data), 32'(v.exp_rdata));
        tick();
        check({nm, "_rsp_pulse"}, rsp_cnt - r0c, 1);
        check({nm, "_invariants"}, viol, 0);
    endtask

    vec_t       vecs[13];
    logic [7:0] rd_m[2];

    initial begin
        int a0, r0c, rc0, r1c, a2c, t;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        sel = 1'b0; slave_byte = '0;

        vecs[0] = mk(0, 1, 8'h3F, 8'h23, 8'h00, 17'h13F23, 68, 8'h00);
        vecs[1] = mk(0, 0, 8'h64, 8'h77, 8'hA5, 17'h06400, 68, 8'hA5);
        vecs[2] = mk(0, 1, 8'h00, 8'hFF, 8'h3C, 17'h100FF, 68, 8'hA5);
        vecs[3] = mk(1, 1, 8'hFF, 8'h00, 8'h00, 17'h1FF00, 34, 8'h00);
        vecs[4] = mk(1, 0, 8'h81, 8'hEE, 8'h5A, 17'h08100, 34, 8'h5A);
        rd_m[0] = 8'hA5;
        rd_m[1] = 8'h5A;
        for (int i = 5; i < 13; i++) begin
            bit s, w;
            logic [7:0] a, d, sb;
            s = 1'($urandom); w = 1'($urandom);
            a = 8'($urandom); d = 8'($urandom); sb = 8'($urandom);
            if (!w) rd_m[s] = sb;
            vecs[i] = mk(s, w, a, d, sb, model_bits(w, a, d), 17 * 2 * (s ? 1 : 2), rd_m[s]);
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_div2", {24'h0, cs0, sc0, so0, rv0, cl0, al0, dl0, r0}, 32'h80);
        check("reset_outs_div1", {24'h0, cs1, sc1, so1, rv1, cl1, al1, dl1, r1}, 32'h80);
        check("reset_rdata", {16'h0, rd0, rd1}, 0);
        reset = 1'b0;
        check("ready_low_after_reset", 32'(r0), 0);
        @(posedge clk); #1;
        check("ready_high_after_reset", {30'h0, r0, r1}, 3);

        for (int i = 0; i < 13; i++) do_frame(i, vecs[i]);

        // back-to-back with req_valid held, request fields changed mid-frame
        sel = 1'b0;
        @(posedge clk); #1;
        a0 = acc_cnt; r0c = rsp_cnt;
        req_write = 1'b1; req_addr = 8'h5C; req_wdata = 8'h96; req_valid = 1'b1;
        wait_acc("b2b_first", a0 + 1);
        repeat (20) @(posedge clk);
        #1;
        req_addr = 8'hC3; req_wdata = 8'h18;
        wait_rsp("b2b_first", r0c + 1);
        r1c = rsp_cyc;
        check("b2b_first_bits", 32'(cap_bits), 32'(model_bits(1'b1, 8'h5C, 8'h96)));
        check("busy_no_accept", acc_cnt - a0, 1);
        wait_acc("b2b_second", a0 + 2);
        a2c = acc_cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tick();
        check("b2b_accept_after_done", a2c - r1c, 1);
        check("b2b_cs_high_gap", cs_fall_cyc - cs_rise_cyc, 2);
        wait_rsp("b2b_second", r0c + 2);
        check("b2b_rsp_spacing", rsp_cyc - r1c, 70);
        check("b2b_second_bits", 32'(cap_bits), 32'(model_bits(1'b1, 8'hC3, 8'h18)));

        // reset during the 4th address bit of a read
        slave_byte = 8'hFF;
        @(posedge clk); #1;
        a0 = acc_cnt; rc0 = rise_cnt;
        req_write = 1'b0; req_addr = 8'hF0; req_valid = 1'b1;
        wait_acc("abort", a0 + 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while ((rise_cnt - rc0) < 5 && t < 200) begin
            tick();
            t++;
        end
        check("abort_reached_addr_bit4", rise_cnt - rc0, 5);
        @(posedge clk); #1;
        r0c = rsp_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_outs", {24'h0, cs0, sc0, so0, rv0, cl0, al0, dl0, r0}, 32'h80);
        check("abort_rdata", 32'(rd0), 0);
        @(posedge clk); #1;
        check("abort_ready_next", 32'(r0), 1);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_cnt - r0c, 0);
        check("abort_cs_idle", {30'h0, cs0, sc0}, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
